// File: rtl/conv_sequencer.sv
// Control sequencer for the convolution compute top: runs one 4x4 / 3x3 / 2x2 convolution
// in single, 2by2 or 3by3 mode, then streams the four result words over valid/ready.
module conv_sequencer #(
    parameter int PIPE_LAT  = 4,
    parameter int ZERO_ADDR = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       abort,
    input  logic       result_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       result_valid,
    output logic [1:0] result_mode,
    output logic [4:0] input_array_addr_in_single,
    output logic [4:0] filter_ceiling_array_addr_in_single,
    output logic       sys_single_en,
    output logic       buffer_we_en_C11_single,
    output logic       buffer_we_en_C12_single,
    output logic       buffer_we_en_C21_single,
    output logic       buffer_we_en_C22_single,
    output logic [4:0] input_array_addr_in_2by2,
    output logic [4:0] filter_ceiling_first_array_addr_in_2by2,
    output logic [4:0] filter_ceiling_second_array_addr_in_2by2,
    output logic       sys_2by2_en,
    output logic [4:0] input_side_array_addr_in_3by3,
    output logic [4:0] input_ceiling_array_addr_in_3by3,
    output logic [4:0] filter_side_array_addr_in_3by3,
    output logic [4:0] filter_ceiling_array_addr_in_3by3,
    output logic       sys_3by3_en,
    output logic [1:0] buffer_read_addr_in_single,
    output logic [1:0] buffer_read_addr_in_2by2,
    output logic [1:0] buffer_read_addr_in_3by3,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FEED  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int         CW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [4:0] ZA     = 5'(ZERO_ADDR);
    localparam logic [1:0] M_SGL  = 2'd0;
    localparam logic [1:0] M_2BY2 = 2'd1;
    localparam logic [1:0] M_3BY3 = 2'd2;
    localparam logic [1:0] M_BAD  = 2'd3;

    state_t          r_state, w_state;
    logic [1:0]      r_mode, w_mode;
    logic [1:0]      r_pos, w_pos;
    logic [3:0]      r_tap, w_tap;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [1:0]      r_ridx, w_ridx;
    logic            r_valid, w_valid;
    logic [3:0]      w_last_tap;

    // Handshake: a result word moves on a clock edge where result_valid and result_ready
    // are both high; the read address then advances and result_valid drops for one cycle.
    always_comb begin
        w_state    = r_state;
        w_mode     = r_mode;
        w_pos      = r_pos;
        w_tap      = r_tap;
        w_cnt      = r_cnt;
        w_ridx     = r_ridx;
        w_valid    = r_valid;
        w_last_tap = (r_mode == M_2BY2) ? 4'd11 : 4'd8;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mode  = mode;
                    w_pos   = 2'd0;
                    w_tap   = 4'd0;
                    w_state = (mode == M_BAD) ? S_DONE : S_FEED;
                end
            end
            S_FEED: begin
                if (r_tap != w_last_tap) begin
                    w_tap = r_tap + 4'd1;
                end else if (r_mode == M_2BY2 && r_pos == 2'd0) begin
                    w_pos = 2'd1;
                    w_tap = 4'd0;
                end else begin
                    w_state = S_DRAIN;
                    w_cnt   = '0;
                end
            end
            S_DRAIN: begin
                if (r_cnt != CW'(PIPE_LAT - 1)) begin
                    w_cnt = r_cnt + 1'b1;
                end else if (r_mode == M_SGL) begin
                    w_state = S_WRITE;
                end else begin
                    w_state = S_READ;
                    w_ridx  = 2'd0;
                    w_valid = 1'b0;
                end
            end
            S_WRITE: begin
                if (r_pos != 2'd3) begin
                    w_state = S_FEED;
                    w_pos   = r_pos + 2'd1;
                    w_tap   = 4'd0;
                end else begin
                    w_state = S_READ;
                    w_ridx  = 2'd0;
                    w_valid = 1'b0;
                end
            end
            S_READ: begin
                if (!r_valid) begin
                    w_valid = 1'b1;
                end else if (result_ready) begin
                    w_valid = 1'b0;
                    if (r_ridx == 2'd3) w_state = S_DONE;
                    else                w_ridx  = r_ridx + 2'd1;
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
        if (abort && r_state != S_IDLE) begin
            w_state = S_IDLE;
            w_valid = 1'b0;
        end
    end

    // Operand addresses are decoded from the next-cycle tap so the registered outputs line up with the state.
    logic [4:0] w_k, w_i, w_j, w_r, w_c, w_i2, w_col, w_p;
    logic       w_feed, w_eng;
    always_comb begin
        w_k    = {1'b0, w_tap};
        w_i    = w_k / 5'd3;
        w_j    = w_k % 5'd3;
        w_r    = {4'd0, w_pos[1]};
        w_c    = {4'd0, w_pos[0]};
        w_i2   = {3'd0, w_tap[3:2]};
        w_col  = {3'd0, w_tap[1:0]};
        w_p    = {4'd0, w_pos[0]};
        w_feed = (w_state == S_FEED);
        w_eng  = (w_state == S_FEED) || (w_state == S_DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_mode       <= 2'd0;
            r_pos        <= 2'd0;
            r_tap        <= 4'd0;
            r_cnt        <= '0;
            r_ridx       <= 2'd0;
            r_valid      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            result_valid <= 1'b0;
            result_mode  <= 2'd0;
            input_array_addr_in_single               <= ZA;
            filter_ceiling_array_addr_in_single      <= ZA;
            sys_single_en                            <= 1'b0;
            buffer_we_en_C11_single                  <= 1'b0;
            buffer_we_en_C12_single                  <= 1'b0;
            buffer_we_en_C21_single                  <= 1'b0;
            buffer_we_en_C22_single                  <= 1'b0;
            input_array_addr_in_2by2                 <= ZA;
            filter_ceiling_first_array_addr_in_2by2  <= ZA;
            filter_ceiling_second_array_addr_in_2by2 <= ZA;
            sys_2by2_en                              <= 1'b0;
            input_side_array_addr_in_3by3            <= ZA;
            input_ceiling_array_addr_in_3by3         <= ZA;
            filter_side_array_addr_in_3by3           <= ZA;
            filter_ceiling_array_addr_in_3by3        <= ZA;
            sys_3by3_en                              <= 1'b0;
            buffer_read_addr_in_single               <= 2'd0;
            buffer_read_addr_in_2by2                 <= 2'd0;
            buffer_read_addr_in_3by3                 <= 2'd0;
        end else begin
            r_state      <= w_state;
            r_mode       <= w_mode;
            r_pos        <= w_pos;
            r_tap        <= w_tap;
            r_cnt        <= w_cnt;
            r_ridx       <= w_ridx;
            r_valid      <= w_valid;
            busy         <= (w_state != S_IDLE);
            done         <= (w_state == S_DONE);
            err          <= (w_state == S_DONE) && (w_mode == M_BAD);
            result_valid <= (w_state == S_READ) && w_valid;
            result_mode  <= (w_state == S_IDLE) ? 2'd0 : w_mode;

            sys_single_en <= w_eng && (w_mode == M_SGL);
            sys_2by2_en   <= w_eng && (w_mode == M_2BY2);
            sys_3by3_en   <= w_eng && (w_mode == M_3BY3);

            input_array_addr_in_single          <= (w_feed && w_mode == M_SGL) ? (((w_r + w_i) << 2) + w_c + w_j) : ZA;
            filter_ceiling_array_addr_in_single <= (w_feed && w_mode == M_SGL) ? (5'd16 + 5'd3 * w_i + w_j) : ZA;

            input_array_addr_in_2by2 <= (w_feed && w_mode == M_2BY2) ? (((w_p + w_i2) << 2) + w_col) : ZA;
            filter_ceiling_first_array_addr_in_2by2 <=
                (w_feed && w_mode == M_2BY2 && w_col != 5'd3) ? (5'd16 + 5'd3 * w_i2 + w_col) : ZA;
            filter_ceiling_second_array_addr_in_2by2 <=
                (w_feed && w_mode == M_2BY2 && w_col != 5'd0) ? (5'd15 + 5'd3 * w_i2 + w_col) : ZA;

            input_side_array_addr_in_3by3     <= (w_feed && w_mode == M_3BY3) ? ((w_i << 2) + w_j) : ZA;
            input_ceiling_array_addr_in_3by3  <= (w_feed && w_mode == M_3BY3) ? (((w_i + 5'd1) << 2) + w_j + 5'd1) : ZA;
            filter_side_array_addr_in_3by3    <= (w_feed && w_mode == M_3BY3) ? (5'd16 + 5'd3 * w_i + w_j) : ZA;
            filter_ceiling_array_addr_in_3by3 <= (w_feed && w_mode == M_3BY3) ? (5'd16 + 5'd3 * w_i + w_j) : ZA;

            buffer_we_en_C11_single <= (w_state == S_WRITE) && (w_pos == 2'd0);
            buffer_we_en_C12_single <= (w_state == S_WRITE) && (w_pos == 2'd1);
            buffer_we_en_C21_single <= (w_state == S_WRITE) && (w_pos == 2'd2);
            buffer_we_en_C22_single <= (w_state == S_WRITE) && (w_pos == 2'd3);

            buffer_read_addr_in_single <= (w_state == S_READ && w_mode == M_SGL)  ? w_ridx : 2'd0;
            buffer_read_addr_in_2by2   <= (w_state == S_READ && w_mode == M_2BY2) ? w_ridx : 2'd0;
            buffer_read_addr_in_3by3   <= (w_state == S_READ && w_mode == M_3BY3) ? w_ridx : 2'd0;
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: random jobs compared cycle by cycle against a trace built from the address formulas.
module tb_conv_sequencer;

    localparam int PL = 4;
    localparam int ZA = 25;

    typedef struct packed {
        logic       en_s;
        logic [3:0] we;
        logic [4:0] in_s, f_s;
        logic [4:0] in_2, f1_2, f2_2;
        logic       en_2;
        logic [4:0] is_3, ic_3, fs_3, fc_3;
        logic       en_3;
        logic       busy, done, err, rv;
        logic [1:0] rmode, rd_s, rd_2, rd_3;
    } obs_t;

    logic clk, rst, start, abort, result_ready;
    logic [1:0] mode;
    logic busy, done, err, result_valid;
    logic [1:0] result_mode;
    logic [4:0] in_s, f_s, in_2, f1_2, f2_2, is_3, ic_3, fs_3, fc_3;
    logic en_s, en_2, en_3, we11, we12, we21, we22;
    logic [1:0] rd_s, rd_2, rd_3;
    logic [2:0] dbg_state;

    logic [63:0] exp_q[$];
    int n_checks, n_fail;
    obs_t obs;

    conv_sequencer #(.PIPE_LAT(PL), .ZERO_ADDR(ZA)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .result_ready(result_ready),
        .busy(busy), .done(done), .err(err), .result_valid(result_valid),
        .result_mode(result_mode),
        .input_array_addr_in_single(in_s),
        .filter_ceiling_array_addr_in_single(f_s),
        .sys_single_en(en_s),
        .buffer_we_en_C11_single(we11),
        .buffer_we_en_C12_single(we12),
        .buffer_we_en_C21_single(we21),
        .buffer_we_en_C22_single(we22),
        .input_array_addr_in_2by2(in_2),
        .filter_ceiling_first_array_addr_in_2by2(f1_2),
        .filter_ceiling_second_array_addr_in_2by2(f2_2),
        .sys_2by2_en(en_2),
        .input_side_array_addr_in_3by3(is_3),
        .input_ceiling_array_addr_in_3by3(ic_3),
        .filter_side_array_addr_in_3by3(fs_3),
        .filter_ceiling_array_addr_in_3by3(fc_3),
        .sys_3by3_en(en_3),
        .buffer_read_addr_in_single(rd_s),
        .buffer_read_addr_in_2by2(rd_2),
        .buffer_read_addr_in_3by3(rd_3),
        .o_dbg_state(dbg_state)
    );

    assign obs = {en_s, we11, we12, we21, we22, in_s, f_s, in_2, f1_2, f2_2, en_2,
                  is_3, ic_3, fs_3, fc_3, en_3, busy, done, err, result_valid,
                  result_mode, rd_s, rd_2, rd_3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t idle_v();
        obs_t e;
        e = '0;
        e.in_s = 5'(ZA); e.f_s  = 5'(ZA);
        e.in_2 = 5'(ZA); e.f1_2 = 5'(ZA); e.f2_2 = 5'(ZA);
        e.is_3 = 5'(ZA); e.ic_3 = 5'(ZA); e.fs_3 = 5'(ZA); e.fc_3 = 5'(ZA);
        return e;
    endfunction

    function automatic obs_t busy_v(input logic [1:0] m);
        obs_t e;
        e = idle_v();
        e.busy  = 1'b1;
        e.rmode = m;
        return e;
    endfunction

    task automatic check(input string tag, input obs_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected engine-phase trace, one entry per cycle from the first feed cycle until READ.
    task automatic build(input logic [1:0] m);
        obs_t e;
        exp_q.delete();
        if (m == 2'd0) begin
            for (int p = 0; p < 4; p++) begin
                for (int k = 0; k < 9; k++) begin
                    e = busy_v(m); e.en_s = 1'b1;
                    e.in_s = 5'(4 * (p / 2 + k / 3) + p % 2 + k % 3);
                    e.f_s  = 5'(16 + k);
                    exp_q.push_back(e);
                end
                for (int d = 0; d < PL; d++) begin
                    e = busy_v(m); e.en_s = 1'b1; exp_q.push_back(e);
                end
                e = busy_v(m); e.we = 4'(8 >> p); exp_q.push_back(e);
            end
        end else if (m == 2'd1) begin
            for (int p = 0; p < 2; p++)
                for (int i = 0; i < 3; i++)
                    for (int col = 0; col < 4; col++) begin
                        e = busy_v(m); e.en_2 = 1'b1;
                        e.in_2 = 5'(4 * (p + i) + col);
                        e.f1_2 = (col < 3) ? 5'(16 + 3 * i + col) : 5'(ZA);
                        e.f2_2 = (col > 0) ? 5'(16 + 3 * i + col - 1) : 5'(ZA);
                        exp_q.push_back(e);
                    end
            for (int d = 0; d < PL; d++) begin
                e = busy_v(m); e.en_2 = 1'b1; exp_q.push_back(e);
            end
        end else begin
            for (int k = 0; k < 9; k++) begin
                e = busy_v(m); e.en_3 = 1'b1;
                e.is_3 = 5'(4 * (k / 3) + k % 3);
                e.ic_3 = 5'(4 * (k / 3 + 1) + k % 3 + 1);
                e.fs_3 = 5'(16 + k);
                e.fc_3 = 5'(16 + k);
                exp_q.push_back(e);
            end
            for (int d = 0; d < PL; d++) begin
                e = busy_v(m); e.en_3 = 1'b1; exp_q.push_back(e);
            end
        end
    endtask

    // pol: 0 = ready tied high, 1 = random ready, 2 = ready low for 5 cycles on word 2
    task automatic run_job(input logic [1:0] m, input int pol);
        obs_t e;
        logic r;
        build(m);
        start = 1'b1; mode = m;
        step();
        start = 1'b0;
        if (m == 2'd3) begin
            e = busy_v(m); e.done = 1'b1; e.err = 1'b1;
            check("bad_mode_done", e);
            step();
            check("bad_mode_idle", idle_v());
            return;
        end
        for (int idx = 0; idx < exp_q.size(); idx++) begin
            check($sformatf("eng_m%0d_c%0d", m, idx), obs_t'(exp_q[idx]));
            start = ($urandom_range(0, 3) == 0);
            mode  = 2'($urandom_range(0, 3));
            step();
        end
        start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            e = busy_v(m);
            case (m)
                2'd0:    e.rd_s = 2'(w);
                2'd1:    e.rd_2 = 2'(w);
                default: e.rd_3 = 2'(w);
            endcase
            check($sformatf("rd_gap_m%0d_w%0d", m, w), e);
            result_ready = (pol == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
            e.rv = 1'b1;
            for (int h = 0; h < 20; h++) begin
                check($sformatf("rd_valid_m%0d_w%0d_h%0d", m, w, h), e);
                if (pol == 0)      r = 1'b1;
                else if (pol == 1) r = (h >= 15) ? 1'b1 : ($urandom_range(0, 2) != 0);
                else               r = !(w == 2 && h < 5);
                result_ready = r;
                step();
                if (r) break;
            end
        end
        result_ready = 1'b1;
        e = busy_v(m); e.done = 1'b1;
        check($sformatf("done_m%0d", m), e);
        step();
        check($sformatf("after_done_m%0d", m), idle_v());
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; mode = 2'd0; abort = 1'b0; result_ready = 1'b1;
        #2 rst = 1'b0;
        #1 check("reset", idle_v());
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        step();
        check("idle_after_reset", idle_v());

        run_job(2'd0, 0);
        run_job(2'd1, 2);
        run_job(2'd2, 1);
        run_job(2'd3, 0);
        run_job(2'd0, 2);

        // abort two cycles into DRAIN of a 3by3 job
        start = 1'b1; mode = 2'd2;
        step();
        start = 1'b0;
        repeat (10) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle", idle_v());
        for (int c = 0; c < 20; c++) begin
            step();
            check($sformatf("abort_quiet_%0d", c), idle_v());
        end

        // asynchronous reset during single position 2, tap 3
        start = 1'b1; mode = 2'd0;
        step();
        start = 1'b0;
        repeat (31) step();
        #2 rst = 1'b0;
        #1 check("async_rst", idle_v());
        @(negedge clk) rst = 1'b1;
        step();
        run_job(2'd0, 0);

        for (int j = 0; j < 8; j++)
            run_job(2'($urandom_range(0, 3)), $urandom_range(0, 2));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
